// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the RAM port A arbiter.
//   arb_state_e : arbiter FSM states
//   BSEL_*      : RAM access-size encoding, shared with the ram block
package mem_arb_pkg;

   typedef enum logic [1:0] {
      CPU      = 2'd0,   // CPU drives port A
      DRAIN    = 2'd1,   // CPU halted, its last stores still reach the RAM
      DBG_IDLE = 2'd2,   // debug owns port A, ready for a transaction
      DBG_RD   = 2'd3    // debug read in flight, waiting for RAM data
   } arb_state_e;

   localparam logic [1:0] BSEL_BYTE = 2'b00;
   localparam logic [1:0] BSEL_HALF = 2'b01;
   localparam logic [1:0] BSEL_WORD = 2'b10;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares RAM port A between the CPU load/store path and a host debug
// requester. A debug session halts the CPU, waits DRAIN_CYCLES so in-flight
// CPU stores land, then serves debug reads/writes over a valid/ready
// handshake. Dropping the session hands the port back to the CPU.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   dbg_session                   level: host requests port ownership
//   dbg_valid/dbg_ready           debug transaction handshake
//   dbg_we/addr/wdata/byte_sel    debug transaction fields
//   dbg_rvalid/dbg_rdata          one-cycle read-data pulse, registered data
//   dbg_owned                     port A currently owned by debug
//   cpu_halt                      halt request to the CPU
//   cpu_mem_*                     CPU data-port request / read data
//   ram_*                         RAM port A (synchronous read, 1-cycle latency)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              dbg_session,
   input  logic              dbg_valid,
   output logic              dbg_ready,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [1:0]        dbg_byte_sel,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_owned,

   output logic              cpu_halt,
   input  logic [ADDR_W-1:0] cpu_mem_addr,
   input  logic [DATA_W-1:0] cpu_mem_wdata,
   input  logic              cpu_mem_we,
   input  logic [1:0]        cpu_byte_sel,
   output logic [DATA_W-1:0] cpu_mem_rdata,

   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic [1:0]        ram_byte_sel,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int                CNT_W    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DRAIN_CYCLES);

   arb_state_e        state, state_nxt;
   logic [CNT_W-1:0]  drain_cnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_byte_sel;
   logic              rd_accept;

   assign rd_accept     = (state == DBG_IDLE) && dbg_valid && !dbg_we;
   assign cpu_mem_rdata = ram_rdata;

   // ---------------------------------------------------------------------
   // State register, drain counter, read address latch, read data register
   // ---------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others; blocking here would create order-
   // dependent simulation and mismatch the synthesized flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= CPU;
         drain_cnt   <= '0;
         rd_addr     <= '0;
         rd_byte_sel <= BSEL_WORD;
         dbg_rvalid  <= 1'b0;
         dbg_rdata   <= '0;
      end else begin
         state <= state_nxt;

         // Loads 0 while the CPU owns the port so DRAIN always starts from 0;
         // saturates at DRAIN_CYCLES instead of wrapping.
         if (state == CPU) begin
            drain_cnt <= '0;
         end else if (state == DRAIN && drain_cnt != CNT_MAX) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
         end

         // Held for DBG_RD so the RAM sees a stable address while dbg_addr
         // is free to change after the handshake.
         if (rd_accept) begin
            rd_addr     <= dbg_addr;
            rd_byte_sel <= dbg_byte_sel;
         end

         // RAM data for the address presented in the accept cycle is valid
         // during DBG_RD; capture it on the DBG_RD -> DBG_IDLE edge.
         dbg_rvalid <= (state == DBG_RD);
         if (state == DBG_RD) begin
            dbg_rdata <= ram_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         CPU: begin
            if (dbg_session) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!dbg_session)               state_nxt = CPU;
            else if (drain_cnt == CNT_LAST) state_nxt = DBG_IDLE;
         end
         DBG_IDLE: begin
            // A transaction presented with the session drop is served first.
            if (rd_accept)                        state_nxt = DBG_RD;
            else if (!dbg_session && !dbg_valid)  state_nxt = CPU;
         end
         DBG_RD: begin
            state_nxt = DBG_IDLE;
         end
         default: state_nxt = CPU;
      endcase
   end

   // ---------------------------------------------------------------------
   // Status outputs and port A mux (combinational from state)
   // ---------------------------------------------------------------------
   always_comb begin
      cpu_halt     = (state != CPU);
      dbg_ready    = (state == DBG_IDLE);
      dbg_owned    = (state == DBG_IDLE) || (state == DBG_RD);

      ram_addr     = cpu_mem_addr;
      ram_wdata    = cpu_mem_wdata;
      ram_we       = cpu_mem_we;
      ram_byte_sel = cpu_byte_sel;

      unique case (state)
         CPU, DRAIN: begin
            // CPU keeps the port through DRAIN so in-flight stores land.
         end
         DBG_IDLE: begin
            ram_addr     = dbg_addr;
            ram_wdata    = dbg_wdata;
            ram_we       = dbg_valid && dbg_we;
            ram_byte_sel = dbg_byte_sel;
         end
         DBG_RD: begin
            ram_addr     = rd_addr;
            ram_wdata    = dbg_wdata;
            ram_we       = 1'b0;
            ram_byte_sel = rd_byte_sel;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter (DRAIN_CYCLES=2) against a small synchronous RAM
// model. A table of per-cycle input/expected-output records covers the main
// session flow; hand-written sequences cover reset state and reset in DBG_RD.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              dbg_session, dbg_valid, dbg_ready, dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [1:0]        dbg_byte_sel;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_owned, cpu_halt;
   logic [ADDR_W-1:0] cpu_mem_addr;
   logic [DATA_W-1:0] cpu_mem_wdata;
   logic              cpu_mem_we;
   logic [1:0]        cpu_byte_sel;
   logic [DATA_W-1:0] cpu_mem_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [1:0]        ram_byte_sel;
   logic [DATA_W-1:0] ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DRAIN_CYCLES(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .dbg_session(dbg_session), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_byte_sel(dbg_byte_sel), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dbg_owned(dbg_owned), .cpu_halt(cpu_halt),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_mem_we(cpu_mem_we), .cpu_byte_sel(cpu_byte_sel),
      .cpu_mem_rdata(cpu_mem_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_byte_sel(ram_byte_sel), .ram_rdata(ram_rdata)
   );

   // Synchronous-read RAM model, 256 words, byte lanes per byte_sel.
   logic [DATA_W-1:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = '0;

   always @(posedge clk) begin
      if (ram_we) begin
         case (ram_byte_sel)
            BSEL_BYTE: mem[ram_addr[9:2]][{ram_addr[1:0], 3'b000} +: 8]  <= ram_wdata[7:0];
            BSEL_HALF: mem[ram_addr[9:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wdata[15:0];
            default:   mem[ram_addr[9:2]] <= ram_wdata;
         endcase
      end
      ram_rdata <= mem[ram_addr[9:2]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        sess, valid, we;
      logic [31:0] daddr, dwdata;
      logic        cwe;
      logic [31:0] caddr, cwdata;
      logic        e_halt, e_ready, e_owned, e_rvalid, e_ram_we;
      logic [31:0] e_ram_addr, e_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      input logic sess, valid, we, input logic [31:0] daddr, dwdata,
      input logic cwe, input logic [31:0] caddr, cwdata,
      input logic e_halt, e_ready, e_owned, e_rvalid, e_ram_we,
      input logic [31:0] e_ram_addr, e_rdata);
      vec_t v;
      v.sess = sess; v.valid = valid; v.we = we; v.daddr = daddr; v.dwdata = dwdata;
      v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
      v.e_halt = e_halt; v.e_ready = e_ready; v.e_owned = e_owned;
      v.e_rvalid = e_rvalid; v.e_ram_we = e_ram_we;
      v.e_ram_addr = e_ram_addr; v.e_rdata = e_rdata;
      vecs.push_back(v);
   endfunction

   // Hard stop if anything stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got_ready;

      //   sess v we daddr  dwdata      cwe caddr cwdata     halt rdy own rv rwe ram_addr rdata
      add(1, 0, 0, 32'h0,   32'h0,        1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h10,  32'h0);        // 0 CPU: session rises, CPU store
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h40,  32'h0);        // 1 DRAIN cnt 0
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h40,  32'h0);        // 2 DRAIN cnt 1
      add(1, 1, 1, 32'h100, 32'h12345678, 0, 32'h40, 32'h0,        1, 1, 1, 0, 1, 32'h100, 32'h0);        // 3 IDLE: write
      add(1, 1, 0, 32'h100, 32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 0, 0, 32'h100, 32'h0);        // 4 IDLE: read accepted
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 1, 0, 0, 32'h100, 32'h0);        // 5 RD: latched addr
      add(1, 0, 0, 32'h200, 32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 1, 0, 32'h200, 32'h12345678); // 6 IDLE: rvalid
      add(1, 1, 0, 32'h10,  32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 0, 0, 32'h10,  32'h12345678); // 7 IDLE: read 0x10
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 1, 0, 0, 32'h10,  32'h12345678); // 8 RD
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 1, 0, 32'h0,   32'hDEADBEEF); // 9 IDLE: drained store
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 0, 0, 32'h0,   32'hDEADBEEF); // 10 IDLE: release
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 11 CPU
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 12 CPU: session rises
      add(0, 1, 1, 32'h300, 32'hAAAA5555, 0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 13 DRAIN: abort, dbg write ignored
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 14 CPU again
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 15 CPU: session rises
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 16 DRAIN
      add(1, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h40,  32'hDEADBEEF); // 17 DRAIN
      add(0, 1, 0, 32'h100, 32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 0, 0, 32'h100, 32'hDEADBEEF); // 18 IDLE: read + session drop
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 0, 1, 0, 0, 32'h100, 32'hDEADBEEF); // 19 RD
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        1, 1, 1, 1, 0, 32'h0,   32'h12345678); // 20 IDLE: rvalid, release
      add(0, 0, 0, 32'h0,   32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 0, 0, 32'h40,  32'h12345678); // 21 CPU

      // ---- reset ----
      rst_n = 1'b0;
      dbg_session = 1'b0; dbg_valid = 1'b0; dbg_we = 1'b0;
      dbg_addr = '0; dbg_wdata = '0; dbg_byte_sel = BSEL_WORD;
      cpu_mem_addr = 32'h40; cpu_mem_wdata = '0; cpu_mem_we = 1'b0;
      cpu_byte_sel = BSEL_WORD;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("reset.halt",   cpu_halt,   1'b0);
      check("reset.ready",  dbg_ready,  1'b0);
      check("reset.rvalid", dbg_rvalid, 1'b0);
      check("reset.rdata",  dbg_rdata,  32'h0);
      check("reset.owned",  dbg_owned,  1'b0);
      rst_n = 1'b1;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         dbg_session   = vecs[i].sess;
         dbg_valid     = vecs[i].valid;
         dbg_we        = vecs[i].we;
         dbg_addr      = vecs[i].daddr;
         dbg_wdata     = vecs[i].dwdata;
         cpu_mem_we    = vecs[i].cwe;
         cpu_mem_addr  = vecs[i].caddr;
         cpu_mem_wdata = vecs[i].cwdata;
         #1;
         check($sformatf("v%0d.halt", i),     cpu_halt,      vecs[i].e_halt);
         check($sformatf("v%0d.ready", i),    dbg_ready,     vecs[i].e_ready);
         check($sformatf("v%0d.owned", i),    dbg_owned,     vecs[i].e_owned);
         check($sformatf("v%0d.rvalid", i),   dbg_rvalid,    vecs[i].e_rvalid);
         check($sformatf("v%0d.ram_we", i),   ram_we,        vecs[i].e_ram_we);
         check($sformatf("v%0d.ram_addr", i), ram_addr,      vecs[i].e_ram_addr);
         check($sformatf("v%0d.rdata", i),    dbg_rdata,     vecs[i].e_rdata);
         check($sformatf("v%0d.cpu_rdata", i), cpu_mem_rdata, ram_rdata);
      end
      @(negedge clk);
      check("abort.no_write_0x300", mem[8'hC0], 32'h0);
      check("store.landed_0x10",    mem[8'h04], 32'hDEADBEEF);

      // ---- reset asserted in DBG_RD ----
      dbg_session = 1'b1;
      got_ready = 1'b0;
      for (int c = 0; c < 10 && !got_ready; c++) begin
         @(negedge clk); #1;
         got_ready = dbg_ready;
      end
      check("rstrd.reach_idle", got_ready, 1'b1);
      dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      @(negedge clk);
      dbg_valid = 1'b0; dbg_addr = '0;
      #1;
      check("rstrd.in_rd", {dbg_owned, dbg_ready}, 2'b10);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check("rstrd.rvalid", dbg_rvalid, 1'b0);
      check("rstrd.halt",   cpu_halt,   1'b0);
      check("rstrd.ready",  dbg_ready,  1'b0);
      check("rstrd.owned",  dbg_owned,  1'b0);
      check("rstrd.rdata",  dbg_rdata,  32'h0);
      rst_n = 1'b1; dbg_session = 1'b0;
      @(negedge clk); #1;
      check("rstrd.rvalid_after", dbg_rvalid, 1'b0);
      check("rstrd.halt_after",   cpu_halt,   1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Owns the RAM data port (port A) and shares it between the CPU load/store path and a host debug requester. On a debug session request it halts the CPU, waits a fixed drain interval so in-flight CPU stores complete, then serves debug reads and writes through a valid/ready handshake. When the session ends it releases the CPU. It sits between `cpu_top`, the debug host interface and `ram`, and replaces the combinational debug mux.

## Interface
- DRAIN_CYCLES, 2, cycles `cpu_halt` is held before the port switches to debug; legal range ≥1
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- dbg_session  in  1  level; host requests ownership of port A
- dbg_valid  in  1  debug transaction request
- dbg_ready  out  1  arbiter accepts the transaction this cycle
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug byte address
- dbg_wdata  in  DATA_W  debug write data
- dbg_byte_sel  in  2  debug access size, same encoding as RAM `byte_sel`
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid
- dbg_rdata  out  DATA_W  registered read data
- dbg_owned  out  1  port A currently owned by debug
- cpu_halt  out  1  to `cpu_top.halt`
- cpu_mem_addr / cpu_mem_wdata / cpu_mem_we / cpu_byte_sel  in  ADDR_W/DATA_W/1/2  CPU data-port request
- cpu_mem_rdata  out  DATA_W  equal to ram_rdata (passthrough)
- ram_addr / ram_wdata / ram_we / ram_byte_sel  out  ADDR_W/DATA_W/1/2  to RAM port A
- ram_rdata  in  DATA_W  RAM port A read data; synchronous, valid one cycle after the address

## Operation
- States:
  - CPU: CPU drives port A. `cpu_halt`=0.
  - DRAIN: CPU still drives port A. `cpu_halt`=1. A counter counts DRAIN_CYCLES.
  - DBG_IDLE: debug owns the port. `ram_we`=0 unless a write is accepted. `dbg_ready`=1.
  - DBG_RD: read in flight. `ram_addr` is driven from the latched address. `ram_we`=0.
- Transitions:
  - CPU→DRAIN when `dbg_session`=1. The counter loads 0.
  - DRAIN→DBG_IDLE when the counter reaches DRAIN_CYCLES−1.
  - DRAIN→CPU immediately if `dbg_session`=0. The drain is aborted.
  - DBG_IDLE with `dbg_valid`=1 and `dbg_we`=1: the write goes to the RAM combinationally in the same cycle (`ram_we`=1 with the dbg fields). State stays DBG_IDLE.
  - DBG_IDLE with `dbg_valid`=1 and `dbg_we`=0: `ram_addr`=`dbg_addr` this cycle and the address is latched. Next state is DBG_RD.
  - DBG_RD→DBG_IDLE always. On that edge `dbg_rdata` loads `ram_rdata` and `dbg_rvalid` is set. `dbg_rvalid` clears on the following edge.
  - DBG_IDLE→CPU when `dbg_session`=0 and `dbg_valid`=0. If `dbg_valid`=1 in the same cycle, the transaction is served first.
- `dbg_ready`=0 in CPU, DRAIN and DBG_RD. No back-to-back reads: at most one read is outstanding.
- `dbg_owned`=1 in DBG_IDLE and DBG_RD.
- `cpu_halt`=1 in every state except CPU.
- If `dbg_session` drops during DBG_RD, the read still completes and `dbg_rvalid` still pulses. The arbiter then returns to CPU via DBG_IDLE.

## Timing
- Reset values: state CPU, `cpu_halt`=0, `dbg_ready`=0, `dbg_rvalid`=0, `dbg_rdata`=0, `dbg_owned`=0, drain counter 0.
- Reset mid-transaction discards the transaction. No `dbg_rvalid` is produced.
- Halt latency: `dbg_session` rising in cycle T gives `cpu_halt`=1 from T+1. The first `dbg_ready`=1 is at T+1+DRAIN_CYCLES.
- Write latency: accepted in cycle T, RAM written at the end of T.
- Read latency: accepted at T, `dbg_rvalid`=1 at T+2. `dbg_ready` returns to 1 at T+2.
- Release: `dbg_session`=0 sampled in DBG_IDLE at T gives `cpu_halt`=0 from T+1. The CPU drives the port from T+1.
- The port mux is purely combinational from the state. There are no bubbles beyond the ones stated above.
- Drain counter width is clog2(DRAIN_CYCLES+1). The counter saturates and never wraps.

## Structure
- Package `mem_arb_pkg`: state enum (CPU, DRAIN, DBG_IDLE, DBG_RD) and the `byte_sel` encoding constants (byte, half, word), shared with `ram`.
- Single module, no sub-module. It consists of the FSM, the drain counter, the address latch, the rdata register and the port mux.

## Test plan
- Reset, then `dbg_session`=1 at T with DRAIN_CYCLES=2 -> `cpu_halt`=1 at T+1, `dbg_ready`=1 at T+3, `dbg_owned`=1 at T+3.
- CPU store issued in the cycle `dbg_session` rises (addr 0x10, data 0xDEADBEEF) -> the store lands in RAM. A later debug read of 0x10 returns 0xDEADBEEF.
- Debug write 0x100←0x12345678, then read 0x100 -> `dbg_rvalid` pulses for exactly one cycle, two cycles after acceptance, with `dbg_rdata`=0x12345678. `dbg_ready`=0 in the intervening cycle.
- `dbg_session` dropped during DRAIN -> returns to CPU next cycle, `cpu_halt`=0, no RAM write occurs.
- `dbg_session` dropped in the cycle a read is accepted -> `dbg_rvalid` is still delivered, then `cpu_halt`=0 one cycle later.
- `rst_n`=0 asserted in DBG_RD -> no `dbg_rvalid`, and all outputs take their reset values on the next edge.
